// File: rtl/dual_port_ram.sv
// Simple dual-port RAM (one write port, one registered read port) that clears
// itself after reset. Define DPRAM_BYPASS_EN for write-first collisions; otherwise collisions are read-first.
module dual_port_ram #(
  parameter  int ADDR_W = 8,
  parameter  int DATA_W = 8,
  localparam int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              ready,
  output logic              access_err
);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_data;

  // One physical write port, shared between the clearing sweep and user writes.
  // A write sampled while rst is low is dropped.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = data_in;
    if (rst) begin
      if (state == INIT) begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr;
        mem_wdata = '0;
      end else if (wr_en) begin
        mem_we = 1'b1;
      end
    end
  end

`ifdef DPRAM_BYPASS_EN
  assign rd_data = (wr_en && (wr_addr == rd_addr)) ? data_in : mem[rd_addr];
`else
  assign rd_data = mem[rd_addr];
`endif

  // NOTE: the array has no reset so it maps onto RAM macros; INIT clears it instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= INIT;
      clr_addr   <= '0;
      ready      <= 1'b0;
      rd_valid   <= 1'b0;
      data_out   <= '0;
      access_err <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          clr_addr   <= clr_addr + 1'b1;
          rd_valid   <= 1'b0;
          access_err <= wr_en | rd_en;
          if (clr_addr == {ADDR_W{1'b1}}) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          access_err <= 1'b0;
          rd_valid   <= rd_en;
          if (rd_en) data_out <= rd_data;
        end
      endcase
    end
  end

endmodule
